axi4_mem_slave: RTL and testbench



---
 rtl/axi4_pkg.sv | 13 +
 rtl/axi4_burst_addr.sv | 27 ++
 rtl/axi4_mem_slave.sv | 229 ++++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 burst/response encodings, FSM state types and wrap-length legality
package axi4_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
  endfunction
endpackage

// File: rtl/axi4_burst_addr.sv
// axi4_burst_addr: combinational next-beat address and burst-legality check for one AXI4 channel
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [7:0]    len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_o,
  output logic          err_o
);
  localparam int SMAX = $clog2(DW/8);
  logic [AW-1:0] incr, sum, mask, wrapped;
  logic wrap_ok;
  assign incr = AW'(1) << size_i;
  assign sum = addr_i + incr;
  // container size minus one; wrap keeps the container base and folds the offset
  assign mask = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
  assign wrapped = (addr_i & ~mask) | (sum & mask);
  assign wrap_ok = wrap_len_ok(len_i);
  assign next_o = burst_i == BURST_INCR ? sum :
                  burst_i == BURST_WRAP ? (wrap_ok ? wrapped : sum) : addr_i;
  assign err_o = burst_i == 2'b11 || (burst_i == BURST_WRAP && !wrap_ok) || size_i > 3'(SMAX);
endmodule

// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 slave RAM, independent read/write channels, one burst outstanding per channel.
// Optional AXI4_MEM_BOUNDS_CHECK_EN flags out-of-range beats with SLVERR instead of aliasing.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int IDW = 4,
  parameter int MEM_WORDS = 1024,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic            s_aclk,
  input  logic            s_aresetn,
  input  logic [IDW-1:0]  s_axi_awid,
  input  logic [AW-1:0]   s_axi_awaddr,
  input  logic [7:0]      s_axi_awlen,
  input  logic [2:0]      s_axi_awsize,
  input  logic [1:0]      s_axi_awburst,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [DW-1:0]   s_axi_wdata,
  input  logic [DW/8-1:0] s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [IDW-1:0]  s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [IDW-1:0]  s_axi_arid,
  input  logic [AW-1:0]   s_axi_araddr,
  input  logic [7:0]      s_axi_arlen,
  input  logic [2:0]      s_axi_arsize,
  input  logic [1:0]      s_axi_arburst,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [IDW-1:0]  s_axi_rid,
  output logic [DW-1:0]   s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready
);
  localparam int SB = DW/8;
  localparam int SMAX = $clog2(SB);
  localparam int IW = $clog2(MEM_WORDS);
  localparam logic [AW-1:0] MEM_BYTES = AW'(MEM_WORDS*SB);
`ifdef AXI4_MEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif
  logic [DW-1:0] mem [MEM_WORDS];

  w_state_e wstate_q, wstate_d;
  logic [IDW-1:0] wid_q, wid_d;
  logic [AW-1:0] waddr_q, waddr_d, wnext, woff;
  logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0] wsize_q, wsize_d;
  logic [1:0] wburst_q, wburst_d;
  logic werr_q, werr_d, wover_q, wover_d, wc_err, w_oob, wen;
  logic [IW-1:0] widx;

  axi4_burst_addr #(.AW(AW), .DW(DW)) u_waddr (
    .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_o(wnext), .err_o(wc_err)
  );

  assign woff = waddr_q - BASE_ADDR;
  assign widx = woff[SMAX +: IW];
  assign w_oob = BCHK && woff >= MEM_BYTES;
  assign s_axi_awready = wstate_q == W_IDLE;
  assign s_axi_wready = wstate_q == W_DATA;
  assign s_axi_bvalid = wstate_q == W_RESP;
  assign s_axi_bid = wid_q;
  assign s_axi_bresp = werr_q ? RESP_SLVERR : RESP_OKAY;
  // wover_q marks beats past awlen: accepted, never written
  assign wen = wstate_q == W_DATA && s_axi_wvalid && !wover_q && wsize_q <= 3'(SMAX) && !w_oob;

  always_comb begin
    wstate_d = wstate_q;
    wid_d = wid_q;
    waddr_d = waddr_q;
    wlen_d = wlen_q;
    wsize_d = wsize_q;
    wburst_d = wburst_q;
    wbeat_d = wbeat_q;
    werr_d = werr_q;
    wover_d = wover_q;
    if (wstate_q == W_IDLE && s_axi_awvalid) begin
      wstate_d = W_DATA;
      wid_d = s_axi_awid;
      waddr_d = s_axi_awaddr;
      wlen_d = s_axi_awlen;
      wsize_d = s_axi_awsize;
      wburst_d = s_axi_awburst;
      wbeat_d = '0;
      werr_d = 1'b0;
      wover_d = 1'b0;
    end else if (wstate_q == W_DATA && s_axi_wvalid) begin
      werr_d = werr_q | wover_q | wc_err | w_oob | (s_axi_wlast && !wover_q && wbeat_q != wlen_q);
      wover_d = wover_q | (wbeat_q == wlen_q);
      wbeat_d = wbeat_q + 8'd1;
      waddr_d = wnext;
      wstate_d = s_axi_wlast ? W_RESP : W_DATA;
    end else if (wstate_q == W_RESP && s_axi_bready) begin
      wstate_d = W_IDLE;
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      wstate_q <= W_IDLE;
      wid_q <= '0;
      waddr_q <= '0;
      wlen_q <= '0;
      wsize_q <= '0;
      wburst_q <= '0;
      wbeat_q <= '0;
      werr_q <= 1'b0;
      wover_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wid_q <= wid_d;
      waddr_q <= waddr_d;
      wlen_q <= wlen_d;
      wsize_q <= wsize_d;
      wburst_q <= wburst_d;
      wbeat_q <= wbeat_d;
      werr_q <= werr_d;
      wover_q <= wover_d;
    end
  end

  always_ff @(posedge s_aclk) begin
    if (wen)
      for (int b = 0; b < SB; b++)
        if (s_axi_wstrb[b]) mem[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
  end

  r_state_e rstate_q, rstate_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic [AW-1:0] raddr_q, raddr_d, rnext, rd_addr, roff;
  logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d, rc_len;
  logic [2:0] rsize_q, rsize_d, rc_size;
  logic [1:0] rburst_q, rburst_d, rc_burst, rresp_q;
  logic rlast_q, rlast_d, rc_err, r_oob, rload, ridle;
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] ridx;

  // in R_IDLE the calculator sees the AR fields so beat 0 gets its response the same cycle
  assign ridle = rstate_q == R_IDLE;
  assign rc_len = ridle ? s_axi_arlen : rlen_q;
  assign rc_size = ridle ? s_axi_arsize : rsize_q;
  assign rc_burst = ridle ? s_axi_arburst : rburst_q;

  axi4_burst_addr #(.AW(AW), .DW(DW)) u_raddr (
    .addr_i(raddr_q), .size_i(rc_size), .len_i(rc_len), .burst_i(rc_burst),
    .next_o(rnext), .err_o(rc_err)
  );

  assign rd_addr = ridle ? s_axi_araddr : rnext;
  assign roff = rd_addr - BASE_ADDR;
  assign ridx = roff[SMAX +: IW];
  assign r_oob = BCHK && roff >= MEM_BYTES;
  assign s_axi_arready = ridle;
  assign s_axi_rvalid = rstate_q == R_DATA;
  assign s_axi_rid = rid_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = rlast_q;

  always_comb begin
    rstate_d = rstate_q;
    rid_d = rid_q;
    raddr_d = raddr_q;
    rlen_d = rlen_q;
    rsize_d = rsize_q;
    rburst_d = rburst_q;
    rbeat_d = rbeat_q;
    rlast_d = rlast_q;
    rload = 1'b0;
    if (ridle && s_axi_arvalid) begin
      rstate_d = R_DATA;
      rid_d = s_axi_arid;
      raddr_d = s_axi_araddr;
      rlen_d = s_axi_arlen;
      rsize_d = s_axi_arsize;
      rburst_d = s_axi_arburst;
      rbeat_d = '0;
      rlast_d = s_axi_arlen == 8'd0;
      rload = 1'b1;
    end else if (rstate_q == R_DATA && s_axi_rready) begin
      rstate_d = rlast_q ? R_IDLE : R_DATA;
      raddr_d = rlast_q ? raddr_q : rnext;
      rbeat_d = rbeat_q + 8'd1;
      rlast_d = !rlast_q && rbeat_q + 8'd1 == rlen_q;
      rload = !rlast_q;
    end
  end

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      rstate_q <= R_IDLE;
      rid_q <= '0;
      raddr_q <= '0;
      rlen_q <= '0;
      rsize_q <= '0;
      rburst_q <= '0;
      rbeat_q <= '0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rstate_q <= rstate_d;
      rid_q <= rid_d;
      raddr_q <= raddr_d;
      rlen_q <= rlen_d;
      rsize_q <= rsize_d;
      rburst_q <= rburst_d;
      rbeat_q <= rbeat_d;
      rlast_q <= rlast_d;
      if (rload) begin
        rdata_q <= r_oob ? '0 : mem[ridx];
        rresp_q <= (rc_err || r_oob) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi4_mem_slave.sv
// tb_axi4_mem_slave: directed AXI4 bursts with a queue scoreboard checked by an independent monitor
module tb_axi4_mem_slave;
  import axi4_pkg::*;
  typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_t;
  typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  r_t rq[$];
  b_t bq[$];
  int checks = 0, failures = 0;
  bit toggle = 1'b0;

  always #5 clk = ~clk;

  axi4_mem_slave #(.DW(32), .AW(32), .IDW(4), .MEM_WORDS(1024), .BASE_ADDR(32'h0)) dut (
    .s_aclk(clk), .s_aresetn(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    failures++;
    $display("FAIL %s actual=no_handshake required=handshake", n);
  endtask

  task automatic wait_sig(input int which, input string n);
    int t = 0;
    logic s;
    do begin
      @(negedge clk);
      t++;
      s = which == 0 ? awready : which == 1 ? wready : arready;
    end while (!s && t < 100);
    if (!s) timeout(n);
  endtask

  task automatic drain();
    int t = 0;
    while ((bq.size() != 0 || rq.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) timeout("drain");
    @(posedge clk);
  endtask

  task automatic er(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    rq.push_back({id, d, resp, last});
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [31:0] d0, input logic [3:0] strb, input int nbeats, input logic [1:0] resp);
    bq.push_back({id, resp});
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = BURST_INCR; awvalid = 1'b1;
    wait_sig(0, "aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wdata = d0 + 32'(i); wstrb = strb; wlast = i == nbeats - 1; wvalid = 1'b1;
      wait_sig(1, "w");
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    drain();
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    wait_sig(2, "ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
    drain();
  endtask

  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rready = toggle ? !rready : 1'b1;
    end
  end

  // monitor: pops the scoreboard on each handshake and checks R holds steady while stalled
  initial begin
    r_t held, cur, e;
    b_t be;
    bit stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'(0));
        else begin
          be = bq.pop_front();
          chk("b_id_resp", 64'({bid, bresp}), 64'(be));
        end
      end
      if (rvalid) begin
        cur = {rid, rdata, rresp, rlast};
        if (stalled) chk("r_stable", 64'(cur), 64'(held));
        if (rready) begin
          stalled = 1'b0;
          if (rq.size() == 0) chk("r_unexpected", 64'(rvalid), 64'(0));
          else begin
            e = rq.pop_front();
            chk("r_id_data_resp_last", 64'(cur), 64'(e));
          end
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    {awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0;
    bready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awready", 64'(awready), 64'(1));
    chk("rst_arready", 64'(arready), 64'(1));
    chk("rst_wready", 64'(wready), 64'(0));
    chk("rst_bvalid", 64'(bvalid), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rlast", 64'(rlast), 64'(0));
    chk("rst_bresp", 64'(bresp), 64'(0));
    chk("rst_rresp", 64'(rresp), 64'(0));
    chk("rst_bid", 64'(bid), 64'(0));
    chk("rst_rid", 64'(rid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr(4'h0, 32'h0, 8'd0, 32'h12345678, 4'hF, 1, RESP_OKAY);
    wr(4'h5, 32'h10, 8'd3, 32'hA0, 4'hF, 4, RESP_OKAY);
    for (int i = 0; i < 4; i++) er(4'h5, 32'hA0 + 32'(i), RESP_OKAY, i == 3);
    rd(4'h5, 32'h10, 8'd3, BURST_INCR);
    er(4'h2, 32'hA2, RESP_OKAY, 1'b0);
    er(4'h2, 32'hA3, RESP_OKAY, 1'b0);
    er(4'h2, 32'hA0, RESP_OKAY, 1'b0);
    er(4'h2, 32'hA1, RESP_OKAY, 1'b1);
    rd(4'h2, 32'h18, 8'd3, BURST_WRAP);
    wr(4'h1, 32'h40, 8'd0, 32'hFFFF_FFFF, 4'hF, 1, RESP_OKAY);
    wr(4'h1, 32'h40, 8'd0, 32'h0, 4'b0101, 1, RESP_OKAY);
    er(4'h3, 32'hFF00_FF00, RESP_OKAY, 1'b1);
    rd(4'h3, 32'h40, 8'd0, BURST_INCR);
    wr(4'h6, 32'h80, 8'd7, 32'hB0, 4'hF, 8, RESP_OKAY);
    toggle = 1'b1;
    for (int i = 0; i < 8; i++) er(4'h7, 32'hB0 + 32'(i), RESP_OKAY, i == 7);
    rd(4'h7, 32'h80, 8'd7, BURST_INCR);
    toggle = 1'b0;
    wr(4'h4, 32'h100, 8'd3, 32'hC0, 4'hF, 4, RESP_OKAY);
    wr(4'h4, 32'h100, 8'd3, 32'hD0, 4'hF, 2, RESP_SLVERR);
    er(4'h8, 32'hD0, RESP_OKAY, 1'b0);
    er(4'h8, 32'hD1, RESP_OKAY, 1'b0);
    er(4'h8, 32'hC2, RESP_OKAY, 1'b0);
    er(4'h8, 32'hC3, RESP_OKAY, 1'b1);
    rd(4'h8, 32'h100, 8'd3, BURST_INCR);
    wr(4'h3, 32'h200, 8'd1, 32'h50, 4'hF, 2, RESP_OKAY);
    wr(4'h3, 32'h200, 8'd0, 32'hE0, 4'hF, 2, RESP_SLVERR);
    er(4'hB, 32'hE0, RESP_OKAY, 1'b0);
    er(4'hB, 32'h51, RESP_OKAY, 1'b1);
    rd(4'hB, 32'h200, 8'd1, BURST_INCR);
    er(4'h9, 32'hA0, RESP_SLVERR, 1'b0);
    er(4'h9, 32'hA0, RESP_SLVERR, 1'b1);
    rd(4'h9, 32'h10, 8'd1, 2'b11);
`ifdef AXI4_MEM_BOUNDS_CHECK_EN
    er(4'hA, 32'h0, RESP_SLVERR, 1'b1);
`else
    er(4'hA, 32'h12345678, RESP_OKAY, 1'b1);
`endif
    rd(4'hA, 32'h1000, 8'd0, BURST_INCR);
    repeat (3) @(negedge clk);
    chk("idle_rvalid", 64'(rvalid), 64'(0));
    chk("idle_bvalid", 64'(bvalid), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
